// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues instruction memory reads for the current PC,
// tracks reads in flight, and queues returned words in an in-order buffer that
// feeds decode over a valid/ready handshake. A read is only issued when a
// buffer slot is guaranteed for it, so returned data never overflows.
module instr_fetch_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_en,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // occ + infl never exceeds BUF_DEPTH + MEM_LAT (at most 11), so 4 bits suffice.
    localparam int CW = 4;

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     infl;
    logic [MEM_LAT-1:0] pipe_live;
    logic [ADDR_W-1:0] pipe_addr [MEM_LAT];
    logic [DATA_W-1:0] buf_data  [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr  [BUF_DEPTH];
    logic [DATA_W-1:0] ir_hold;
    logic [ADDR_W-1:0] pc_hold;
    logic              pop;
    logic              wr;
    logic              issue;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ir_valid = (occ != '0);
    assign pop      = ir_valid & ir_ready;
    assign wr       = pipe_live[MEM_LAT-1];

    // Count live reads still travelling through the latency pipe.
    always_comb begin
        infl = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            infl = infl + CW'(pipe_live[i]);
        end
    end

    // Credit check: issue only if every buffered and in-flight word still fits
    // after this cycle's pop.
    always_comb begin
        issue = !rst && !flush && ((occ + infl - CW'(pop)) < CW'(BUF_DEPTH));
    end

    assign mem_rd   = issue;
    assign pc_en    = issue;
    assign mem_addr = pc_addr;

    // An empty buffer keeps showing the last head so decode sees stable values.
    assign ir    = ir_valid ? buf_data[rd_ptr] : ir_hold;
    assign ir_pc = ir_valid ? buf_addr[rd_ptr] : pc_hold;

    // Control state: pointers, occupancy and live bits; rst/flush drop everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            pipe_live <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                pipe_live[i] <= pipe_live[i-1];
            end
            pipe_live[0] <= issue;
            if (wr) begin
                buf_data[wr_ptr] <= mem_rdata;
                buf_addr[wr_ptr] <= pipe_addr[MEM_LAT-1];
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            occ <= occ + CW'(wr) - CW'(pop);
        end
    end

    // Address side of the latency pipe; only meaningful where the live bit is set.
    always_ff @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pipe_addr[i] <= pipe_addr[i-1];
        end
        pipe_addr[0] <= pc_addr;
    end

    // Remember the most recent head so ir/ir_pc hold while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_hold <= '0;
            pc_hold <= '0;
        end else if (ir_valid) begin
            ir_hold <= buf_data[rd_ptr];
            pc_hold <= buf_addr[rd_ptr];
        end
    end

    // A return into a full buffer without a pop means the credit logic is broken.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr && !pop) begin
            assert (occ < CW'(BUF_DEPTH));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-1/depth-2 instance driven from a
// cycle table, and a latency-3/depth-4 instance driven by a streaming sequence.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- instance A: MEM_LAT=1, BUF_DEPTH=2 ----------------
    logic        a_rst, a_flush, a_ready;
    logic [15:0] a_pc = 16'h0000;
    logic [15:0] a_rdata = 16'hDEAD;
    logic        a_pc_en, a_mem_rd, a_valid;
    logic [15:0] a_mem_addr, a_ir, a_ir_pc;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst(a_rst), .pc_addr(a_pc), .pc_en(a_pc_en), .flush(a_flush),
        .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_rdata(a_rdata),
        .ir(a_ir), .ir_pc(a_ir_pc), .ir_valid(a_valid), .ir_ready(a_ready)
    );

    // PC and memory model for A: sample settled outputs mid-cycle, update after the edge.
    initial begin
        logic        s_rst, s_fl, s_en, s_rd;
        logic [15:0] s_ad;
        forever begin
            @(negedge clk);
            s_rst = a_rst; s_fl = a_flush; s_en = a_pc_en; s_rd = a_mem_rd; s_ad = a_mem_addr;
            @(posedge clk);
            #1;
            if (s_rst)     a_pc = 16'h0000;
            else if (s_fl) a_pc = 16'h0040;
            else if (s_en) a_pc = a_pc + 16'h0001;
            a_rdata = s_rd ? s_ad + 16'h0100 : 16'hDEAD;
        end
    end

    // ---------------- instance B: MEM_LAT=3, BUF_DEPTH=4 ----------------
    logic        b_rst, b_flush, b_ready;
    logic [15:0] b_pc = 16'h0000;
    logic [15:0] b_p0 = 16'hDEAD, b_p1 = 16'hDEAD, b_p2 = 16'hDEAD;
    logic        b_pc_en, b_mem_rd, b_valid;
    logic [15:0] b_mem_addr, b_ir, b_ir_pc;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst(b_rst), .pc_addr(b_pc), .pc_en(b_pc_en), .flush(b_flush),
        .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_rdata(b_p2),
        .ir(b_ir), .ir_pc(b_ir_pc), .ir_valid(b_valid), .ir_ready(b_ready)
    );

    initial begin
        logic        s_rst, s_fl, s_en, s_rd;
        logic [15:0] s_ad;
        forever begin
            @(negedge clk);
            s_rst = b_rst; s_fl = b_flush; s_en = b_pc_en; s_rd = b_mem_rd; s_ad = b_mem_addr;
            @(posedge clk);
            #1;
            if (s_rst)     b_pc = 16'h0000;
            else if (s_fl) b_pc = 16'h0040;
            else if (s_en) b_pc = b_pc + 16'h0001;
            b_p2 = b_p1;
            b_p1 = b_p0;
            b_p0 = s_rd ? s_ad + 16'h0100 : 16'hDEAD;
        end
    end

    // ---------------- vector table for A ----------------
    typedef struct {
        logic        rst;
        logic        flush;
        logic        ready;
        logic        en;
        logic        v;
        logic        chk;
        logic [15:0] pc;
        logic [15:0] ir;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic rdy,
                                input logic en, input logic v, input logic [15:0] pc);
        vec_t t;
        t.rst = r; t.flush = f; t.ready = rdy; t.en = en; t.v = v;
        t.chk = v; t.pc = pc; t.ir = pc + 16'h0100;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t z;
        int   exp_next;
        int   pops;

        a_rst = 1'b1; a_flush = 1'b0; a_ready = 1'b1;
        b_rst = 1'b1; b_flush = 1'b0; b_ready = 1'b1;

        // reset held 3 cycles
        repeat (3) tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0));
        // first cycle after release: ir/ir_pc still zero
        z = mk(0, 0, 1, 1, 0, 16'h0); z.chk = 1'b1; z.ir = 16'h0000; tbl.push_back(z);
        // streaming, one word per cycle from cycle 2
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0001));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0002));
        // reset while streaming
        tbl.push_back(mk(1, 0, 1, 0, 1, 16'h0003));
        // backpressure from cycle 2, resume at cycle 5
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0001));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0002));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0003));
        // reset with one buffered entry and addr 5 in flight; refetch from 0
        tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0004));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0001));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0002));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0003));
        // flush with addr 5 in flight, target 0x0040
        tbl.push_back(mk(0, 1, 1, 0, 1, 16'h0004));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0040));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0041));
        // rst and flush together: reset wins, PC back to 0
        tbl.push_back(mk(1, 1, 1, 0, 1, 16'h0042));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            a_rst = tbl[i].rst; a_flush = tbl[i].flush; a_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("A[%0d] pc_en", i), 32'(a_pc_en), 32'(tbl[i].en));
            chk($sformatf("A[%0d] mem_rd", i), 32'(a_mem_rd), 32'(tbl[i].en));
            chk($sformatf("A[%0d] mem_addr", i), 32'(a_mem_addr), 32'(a_pc));
            chk($sformatf("A[%0d] ir_valid", i), 32'(a_valid), 32'(tbl[i].v));
            if (tbl[i].chk) begin
                chk($sformatf("A[%0d] ir_pc", i), 32'(a_ir_pc), 32'(tbl[i].pc));
                chk($sformatf("A[%0d] ir", i), 32'(a_ir), 32'(tbl[i].ir));
            end
            @(posedge clk);
            #1;
        end
        a_rst = 1'b1;

        // B: first word at cycle 4, then one per cycle; later random-ish backpressure
        b_rst = 1'b0;
        exp_next = 0;
        pops = 0;
        for (int k = 0; k < 40; k++) begin
            b_ready = (k < 12) ? 1'b1 : ((k % 3) != 0);
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("B[%0d] ir_valid", k), 32'(b_valid), 32'd0);
                chk($sformatf("B[%0d] pc_en", k), 32'(b_pc_en), 32'd1);
            end else if (k < 12) begin
                chk($sformatf("B[%0d] ir_valid", k), 32'(b_valid), 32'd1);
                chk($sformatf("B[%0d] pc_en", k), 32'(b_pc_en), 32'd1);
            end
            if (b_valid && b_ready) begin
                chk($sformatf("B[%0d] ir_pc", k), 32'(b_ir_pc), 32'(exp_next));
                chk($sformatf("B[%0d] ir", k), 32'(b_ir), 32'(exp_next + 16'h0100));
                exp_next++;
                pops++;
            end
            @(posedge clk);
            #1;
        end
        chk("B pop count", 32'(pops >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
